// File: rtl/ttt_pkg.sv
// Shared definitions for the tic-tac-toe move controller: FSM states,
// player encoding and the default board edge length.
package ttt_pkg;

    localparam int BOARD_DIM_DEF = 3;

    localparam logic PLAYER_X = 1'b0;
    localparam logic PLAYER_O = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // waiting for a press
        ST_HOLD = 2'd1,   // press consumed, waiting for release
        ST_FULL = 2'd2    // board complete, only clear/reset leaves
    } state_e;

endpackage

// File: rtl/ttt_debounce.sv
// Counter-based stable-level filter for the commit button. The output level
// follows the input only after the input has held its new value for CYCLES
// consecutive clocks; any bounce back restarts the count.
// Only built when TTT_DEBOUNCE_EN is defined.
`ifdef TTT_DEBOUNCE_EN
module ttt_debounce #(
    parameter int CYCLES = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic din_i,
    output logic dout_o
);
    localparam int CNT_W = (CYCLES < 2) ? 1 : $clog2(CYCLES);

    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Count consecutive samples that disagree with the filtered level.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (din_i != level_q) begin
            if (cnt_q == CNT_W'(CYCLES - 1)) begin
                level_d = din_i;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Filter state registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign dout_o = level_q;

endmodule
`endif

// File: rtl/ttt_move_controller.sv
// Registered move-entry controller for an N x N tic-tac-toe board.
// Converts a 1-based position switch plus a commit button into a one-cycle
// one-hot cell-write pulse, tracks per-player occupancy, alternates turns
// and rejects illegal moves.
// Optional feature macro: TTT_DEBOUNCE_EN (debounce the COMMIT button).
module ttt_move_controller
    import ttt_pkg::*;
#(
    parameter  int BOARD_DIM       = BOARD_DIM_DEF,
    parameter  int SEL_W           = 4,
    parameter  int DEBOUNCE_CYCLES = 4,
    localparam int CELLS           = BOARD_DIM * BOARD_DIM,
    localparam int CW              = $clog2(CELLS + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [SEL_W-1:0] POS_SW,
    input  logic             ENABLE,
    input  logic             COMMIT,
    input  logic             CLEAR_BOARD,
    output logic [CELLS-1:0] P_EN,
    output logic [CELLS-1:0] X_MAP,
    output logic [CELLS-1:0] O_MAP,
    output logic             PLAYER,
    output logic             MOVE_VALID,
    output logic             MOVE_REJECT,
    output logic [CW-1:0]    MOVE_COUNT,
    output logic             BOARD_FULL
);

    if (2**SEL_W <= CELLS) begin : g_sel_w_too_small
        $error("SEL_W too narrow to encode every cell index");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be at least 1");
    end

    localparam logic [CELLS-1:0] ONE_HOT0 = CELLS'(1);
    localparam logic [CW-1:0]    CELLS_C  = CW'(CELLS);

    // ---------------------------------------------------------------
    // Commit level source
    // ---------------------------------------------------------------
    logic commit_lvl;
`ifdef TTT_DEBOUNCE_EN
    ttt_debounce #(
        .CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk_i  (CLK),
        .rst_i  (RST),
        .din_i  (COMMIT),
        .dout_o (commit_lvl)
    );
`else
    assign commit_lvl = COMMIT;
`endif

    // ---------------------------------------------------------------
    // Edge detect. armed_q blocks a button that was already held through
    // reset from counting as a fresh press: it only sets once the button
    // has been seen released.
    // ---------------------------------------------------------------
    logic commit_prev_q;
    logic armed_q;
    logic commit_evt;

    assign commit_evt = commit_lvl & ~commit_prev_q & armed_q;

    // Previous-level and arming registers for the press edge detector.
    always_ff @(posedge CLK) begin
        if (RST) begin
            commit_prev_q <= 1'b0;
            armed_q       <= ~COMMIT;
        end else begin
            commit_prev_q <= commit_lvl;
            armed_q       <= armed_q | (~COMMIT & ~commit_lvl);
        end
    end

    // ---------------------------------------------------------------
    // Move decode
    // ---------------------------------------------------------------
    logic [SEL_W-1:0] pos_idx;
    logic             pos_ok;
    logic [CELLS-1:0] pos_hot;
    logic             cell_free;
    logic             move_legal;

    assign pos_idx    = POS_SW - SEL_W'(1);
    assign pos_ok     = (POS_SW != '0) && (POS_SW <= SEL_W'(CELLS));
    assign pos_hot    = pos_ok ? (ONE_HOT0 << pos_idx) : '0;
    assign cell_free  = ((X_MAP | O_MAP) & pos_hot) == '0;
    assign move_legal = pos_ok && cell_free && (MOVE_COUNT != CELLS_C);

    // ---------------------------------------------------------------
    // FSM and board state
    // ---------------------------------------------------------------
    state_e           state_q, state_d;
    logic [CELLS-1:0] pen_q, pen_d;
    logic [CELLS-1:0] xmap_q, xmap_d;
    logic [CELLS-1:0] omap_q, omap_d;
    logic             player_q, player_d;
    logic             valid_q, valid_d;
    logic             reject_q, reject_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, full_d;

    // Next-state, board update and pulse generation.
    always_comb begin
        state_d  = state_q;
        pen_d    = '0;
        xmap_d   = xmap_q;
        omap_d   = omap_q;
        player_d = player_q;
        valid_d  = 1'b0;
        reject_d = 1'b0;
        count_d  = count_q;
        full_d   = (count_q == CELLS_C);

        if (CLEAR_BOARD) begin
            state_d  = ST_IDLE;
            xmap_d   = '0;
            omap_d   = '0;
            player_d = PLAYER_X;
            count_d  = '0;
            full_d   = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (commit_evt && ENABLE) begin
                        state_d = ST_HOLD;
                        if (move_legal) begin
                            pen_d    = pos_hot;
                            valid_d  = 1'b1;
                            player_d = ~player_q;
                            count_d  = count_q + CW'(1);
                            if (player_q == PLAYER_X) begin
                                xmap_d = xmap_q | pos_hot;
                            end else begin
                                omap_d = omap_q | pos_hot;
                            end
                        end else begin
                            reject_d = 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!commit_lvl) begin
                        state_d = (count_q == CELLS_C) ? ST_FULL : ST_IDLE;
                    end
                end
                ST_FULL: begin
                    if (commit_evt && ENABLE) begin
                        reject_d = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            pen_q    <= '0;
            xmap_q   <= '0;
            omap_q   <= '0;
            player_q <= PLAYER_X;
            valid_q  <= 1'b0;
            reject_q <= 1'b0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pen_q    <= pen_d;
            xmap_q   <= xmap_d;
            omap_q   <= omap_d;
            player_q <= player_d;
            valid_q  <= valid_d;
            reject_q <= reject_d;
            count_q  <= count_d;
            full_q   <= full_d;
        end
    end

    assign P_EN        = pen_q;
    assign X_MAP       = xmap_q;
    assign O_MAP       = omap_q;
    assign PLAYER      = player_q;
    assign MOVE_VALID  = valid_q;
    assign MOVE_REJECT = reject_q;
    assign MOVE_COUNT  = count_q;
    assign BOARD_FULL  = full_q;

endmodule

// File: tb/tb_ttt_move_controller.sv
// Self-checking bench for ttt_move_controller (BOARD_DIM=3, default build).
// Reference model: a cell-owner array, turn flag and move tally updated
// from the game rules on every press.
module tb_ttt_move_controller;

    logic       CLK = 1'b0;
    logic       RST;
    logic [3:0] POS_SW;
    logic       ENABLE;
    logic       COMMIT;
    logic       CLEAR_BOARD;
    logic [8:0] P_EN;
    logic [8:0] X_MAP;
    logic [8:0] O_MAP;
    logic       PLAYER;
    logic       MOVE_VALID;
    logic       MOVE_REJECT;
    logic [3:0] MOVE_COUNT;
    logic       BOARD_FULL;

    ttt_move_controller #(
        .BOARD_DIM       (3),
        .SEL_W           (4),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .POS_SW      (POS_SW),
        .ENABLE      (ENABLE),
        .COMMIT      (COMMIT),
        .CLEAR_BOARD (CLEAR_BOARD),
        .P_EN        (P_EN),
        .X_MAP       (X_MAP),
        .O_MAP       (O_MAP),
        .PLAYER      (PLAYER),
        .MOVE_VALID  (MOVE_VALID),
        .MOVE_REJECT (MOVE_REJECT),
        .MOVE_COUNT  (MOVE_COUNT),
        .BOARD_FULL  (BOARD_FULL)
    );

    always #5 CLK = ~CLK;

    int vectors = 0;
    int errs    = 0;

    // model: owner[c] for cell c=1..9 (0 empty, 1 X, 2 O)
    int owner [1:9];
    int turn;    // 0 = X to move, 1 = O
    int moves;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic model_clear();
        for (int c = 1; c <= 9; c++) owner[c] = 0;
        turn  = 0;
        moves = 0;
    endtask

    function automatic logic [8:0] model_map(input int who);
        logic [8:0] m = '0;
        for (int c = 1; c <= 9; c++) if (owner[c] == who) m[c-1] = 1'b1;
        return m;
    endfunction

    task automatic chk_board(input string tag);
        chk({tag, ".x_map"}, X_MAP, model_map(1));
        chk({tag, ".o_map"}, O_MAP, model_map(2));
        chk({tag, ".player"}, PLAYER, turn);
        chk({tag, ".count"}, MOVE_COUNT, moves);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".pulses"}, {P_EN, MOVE_VALID, MOVE_REJECT}, 0);
    endtask

    // One button press: rise, hold for `hold` cycles, release for one cycle.
    task automatic press(input int pos, input int hold, input bit en, input string tag);
        bit         legal;
        logic [8:0] hot;
        bit         full_before;
        full_before = (moves == 9);
        POS_SW = 4'(pos);
        ENABLE = en;
        COMMIT = 1'b1;
        tick();
        legal = (pos >= 1) && (pos <= 9) && (moves < 9);
        if (legal) legal = (owner[pos] == 0);
        hot = '0;
        if (en && legal) begin
            hot = 9'(1 << (pos - 1));
            owner[pos] = (turn == 0) ? 1 : 2;
            turn  = 1 - turn;
            moves = moves + 1;
        end
        chk({tag, ".p_en"}, P_EN, hot);
        chk({tag, ".valid"}, MOVE_VALID, en && legal);
        chk({tag, ".reject"}, MOVE_REJECT, en && !legal);
        chk({tag, ".full_lag"}, BOARD_FULL, full_before);
        chk_board(tag);
        for (int i = 1; i < hold; i++) begin
            POS_SW = 4'($urandom_range(0, 15));
            tick();
            chk_quiet({tag, ".hold"});
        end
        COMMIT = 1'b0;
        ENABLE = 1'b1;
        tick();
        chk_quiet({tag, ".rel"});
        chk({tag, ".full"}, BOARD_FULL, moves == 9);
        chk_board({tag, ".rel"});
    endtask

    task automatic clear_board(input string tag);
        CLEAR_BOARD = 1'b1;
        tick();
        CLEAR_BOARD = 1'b0;
        model_clear();
        chk_quiet(tag);
        chk({tag, ".full"}, BOARD_FULL, 0);
        chk_board(tag);
    endtask

    initial begin
        RST = 1'b1; POS_SW = '0; ENABLE = 1'b1; COMMIT = 1'b0; CLEAR_BOARD = 1'b0;
        model_clear();
        tick(); tick();
        RST = 1'b0;
        tick();

        // reset state
        chk_quiet("reset");
        chk("reset.full", BOARD_FULL, 0);
        chk_board("reset");

        // first move and occupied-cell rejection
        press(5, 1, 1'b1, "first5");
        press(5, 1, 1'b1, "again5");
        // out-of-range indices
        press(0, 1, 1'b1, "pos0");
        press(12, 1, 1'b1, "pos12");
        // ENABLE low: ignored, no reject
        press(3, 2, 1'b0, "disabled");
        // long hold: one move only
        press(1, 20, 1'b1, "hold20");

        // full game 1..9
        clear_board("clr1");
        for (int c = 1; c <= 9; c++) press(c, 1, 1'b1, $sformatf("game%0d", c));
        chk("game.x", X_MAP, 9'h155);
        chk("game.o", O_MAP, 9'h0AA);
        press(4, 2, 1'b1, "fullpress");
        clear_board("clr2");

        // clear coincident with a fresh press
        press(2, 1, 1'b1, "pre_coinc");
        POS_SW = 4'd7; COMMIT = 1'b1; CLEAR_BOARD = 1'b1;
        tick();
        CLEAR_BOARD = 1'b0;
        model_clear();
        chk_quiet("coinc");
        chk_board("coinc");
        tick();
        chk_quiet("coinc.held");
        COMMIT = 1'b0;
        tick();

        // reset while a press is held: no move until released and pressed
        press(6, 1, 1'b1, "pre_rst");
        POS_SW = 4'd8; COMMIT = 1'b1;
        tick();
        chk("rst_hold.move", MOVE_VALID, 1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        model_clear();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_quiet("rst_hold");
        end
        chk_board("rst_hold");
        COMMIT = 1'b0;
        tick();
        press(8, 1, 1'b1, "post_rst");

        // randomized play
        for (int n = 0; n < 250; n++) begin
            if ($urandom_range(0, 24) == 0) begin
                clear_board("rnd.clr");
            end else begin
                press(int'($urandom_range(0, 15)), int'($urandom_range(1, 4)),
                      $urandom_range(0, 7) != 0, "rnd");
            end
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
                tick();
                chk_quiet("rnd.gap");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

// File: doc/ttt_move_controller.md
# ttt_move_controller

Registered, parametrised move-entry controller for the N×N tic-tac-toe board.
- Turns a 1-based position-switch value plus a commit button into a single-cycle one-hot cell-write pulse.
- Tracks cell occupancy per player and alternates turns.
- Rejects illegal moves: out-of-range index, occupied cell, full board.
- Sits between the switch/button inputs and the cell-storage and win-detect logic.
- Supersedes the purely combinational position decoder.

## Interface
Parameters:
- BOARD_DIM, 3, board edge length; CELLS = BOARD_DIM*BOARD_DIM (localparam).
- SEL_W, 4, POS_SW width; must satisfy 2**SEL_W > CELLS (elaboration error otherwise).
- DEBOUNCE_CYCLES, 4, stable-high cycles required on COMMIT; used only with TTT_DEBOUNCE_EN.

Ports (one clock, CLK; reset is synchronous and active-high, RST):
- CLK  in  1  system clock, all logic rising-edge.
- RST  in  1  synchronous active-high reset.
- POS_SW  in  SEL_W  1-based cell index; 0 and >CELLS are invalid.
- ENABLE  in  1  game active; commits ignored while low.
- COMMIT  in  1  move button, level input.
- CLEAR_BOARD  in  1  synchronous new-game request.
- P_EN  out  CELLS  one-hot write pulse; bit k = cell k+1.
- X_MAP  out  CELLS  cells owned by X.
- O_MAP  out  CELLS  cells owned by O.
- PLAYER  out  1  side to move; 0 = X, 1 = O.
- MOVE_VALID  out  1  accepted-move pulse, coincident with P_EN.
- MOVE_REJECT  out  1  illegal-commit pulse.
- MOVE_COUNT  out  $clog2(CELLS+1)  moves accepted this game.
- BOARD_FULL  out  1  high when MOVE_COUNT == CELLS.

## Operation
- Reset values:
  - All outputs 0.
  - State IDLE.
  - COMMIT edge register 0.
- commit_evt = COMMIT high this cycle and low last cycle (qualified signal under TTT_DEBOUNCE_EN).
- FSM states:
  - IDLE: on commit_evt && ENABLE, evaluate POS_SW and go to HOLD.
    - Legal (1 ≤ POS_SW ≤ CELLS and cell free in X_MAP|O_MAP):
      - Pulse P_EN and MOVE_VALID.
      - Set the bit in the mover's map.
      - Toggle PLAYER.
      - Increment MOVE_COUNT.
    - Illegal: pulse MOVE_REJECT only; maps, PLAYER and count unchanged.
  - HOLD: wait for COMMIT low, then return to IDLE.
    - Guarantees one move per press regardless of hold length.
    - If the accepted move filled the board, go to FULL instead of IDLE once COMMIT is low.
  - FULL: every commit_evt with ENABLE high pulses MOVE_REJECT; leave only via CLEAR_BOARD or RST.
- ENABLE low: commit_evt is ignored (no reject); maps are held. ENABLE falling while in HOLD does not abort the release wait.
- CLEAR_BOARD:
  - Same effect as RST on maps, PLAYER, MOVE_COUNT, BOARD_FULL and state.
  - Takes priority over a simultaneous commit_evt, so no pulse that cycle.
- RST mid-HOLD: return to IDLE; a COMMIT still held high produces no move until released and pressed again.
- P_EN, MOVE_VALID and MOVE_REJECT are never high together; each is at most one cycle wide.

## Timing
- Latency (no macro): commit_evt in cycle t → P_EN/MOVE_VALID/MOVE_REJECT high in cycle t+1.
  - Maps, PLAYER and MOVE_COUNT update on the same edge.
- POS_SW is sampled only in the commit_evt cycle.
- Minimum press-to-press spacing: 1 low cycle on COMMIT.
- BOARD_FULL is registered and rises in the cycle after the final valid move's pulse.

## Configuration
- TTT_DEBOUNCE_EN defined:
  - COMMIT passes through a debouncer; commit_evt fires once COMMIT has been high for DEBOUNCE_CYCLES consecutive cycles.
  - Any low cycle restarts the count.
  - Release must likewise be stable for DEBOUNCE_CYCLES cycles before HOLD exits.
  - Latency becomes DEBOUNCE_CYCLES+1 cycles from the first high sample.
- Undefined: raw single-flop edge detect as above; DEBOUNCE_CYCLES is unused.

## Structure
- Shared package ttt_pkg:
  - State enum (IDLE, HOLD, FULL).
  - PLAYER_X = 1'b0 / PLAYER_O = 1'b1.
  - Default BOARD_DIM constant.
- Sub-module ttt_debounce (counter-based stable-level filter) is instantiated only under TTT_DEBOUNCE_EN.

## Test plan
All scenarios use BOARD_DIM=3, no macro unless noted.
- After reset, POS_SW=5, COMMIT 0→1 → next cycle: P_EN=9'b000010000 for one cycle, MOVE_VALID=1, X_MAP=9'h010, PLAYER=1, MOVE_COUNT=1.
- Release, POS_SW=5, press again → MOVE_REJECT one cycle, P_EN=0, O_MAP=0, PLAYER stays 1.
- POS_SW=0, then POS_SW=12, each pressed → two MOVE_REJECT pulses, no state change.
- COMMIT held high 20 cycles with POS_SW=1 → exactly one P_EN pulse.
- Play cells 1..9 alternately → X_MAP=9'h155, O_MAP=9'h0AA, BOARD_FULL=1. Further press → MOVE_REJECT. CLEAR_BOARD → all outputs 0, PLAYER=0.
- CLEAR_BOARD coincident with commit_evt → no P_EN or MOVE_REJECT, board cleared. With TTT_DEBOUNCE_EN, DEBOUNCE_CYCLES=4: a 3-cycle COMMIT glitch → no pulse.
